// File: rtl/ex_div_pkg.sv
// ex_div_pkg: operation codes, state encodings and shared constants for the EX-stage divider.
`default_nettype none

package ex_div_pkg;

  localparam int BUS_DIV_OP = 2;

  localparam logic [BUS_DIV_OP-1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [BUS_DIV_OP-1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [BUS_DIV_OP-1:0] DIV_OP_REM  = 2'd2;
  localparam logic [BUS_DIV_OP-1:0] DIV_OP_REMU = 2'd3;

  localparam logic [1:0] DIV_ST_IDLE = 2'd0;
  localparam logic [1:0] DIV_ST_CALC = 2'd1;
  localparam logic [1:0] DIV_ST_DONE = 2'd2;

  localparam logic [63:0] ZERO_DOUBLE   = 64'd0;
  localparam logic [4:0]  REG_ADDR_ZERO = 5'd0;

  function automatic logic op_is_signed(input logic [BUS_DIV_OP-1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [BUS_DIV_OP-1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_div_div_step.sv
// ex_div_div_step: one combinational restoring-division iteration (shift, compare, subtract).
`default_nettype none

module ex_div_div_step #(
  parameter int DW = 64
) (
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] quo,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_next,
  output logic [DW-1:0] quo_next
);

  // One extra bit so a shifted remainder above 2^DW-1 still compares correctly.
  logic [DW:0] partial;
  logic [DW:0] diff;

  assign partial  = {rem, quo[DW-1]};
  assign diff     = partial - {1'b0, divisor};
  assign rem_next = diff[DW] ? partial[DW-1:0] : diff[DW-1:0];
  assign quo_next = {quo[DW-2:0], ~diff[DW]};

endmodule

`default_nettype wire

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for the RV64 EX stage (DIV/DIVU/REM/REMU, W variants).
// Optional EX_DIV_EARLY_OUT_EN: |dividend| < |divisor| finishes without iterating.
`default_nettype none

module ex_div
  import ex_div_pkg::*;
#(
  parameter int DW = 64,
  parameter int CW = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BUS_DIV_OP-1:0] div_op_i,
  input  logic                  word_i,
  input  logic [DW-1:0]         dividend_i,
  input  logic [DW-1:0]         divisor_i,
  input  logic [4:0]            addr_rd_i,
  input  logic                  flush_i,
  output logic                  hold_req_o,
  output logic                  done_o,
  output logic [DW-1:0]         result_o,
  output logic [4:0]            addr_rd_o,
  output logic                  reg_wr_en_o
);

  function automatic logic [DW-1:0] word_fix(input logic [DW-1:0] v, input logic w);
    return w ? {{(DW-32){v[31]}}, v[31:0]} : v;
  endfunction

  logic [1:0]            state;
  logic [BUS_DIV_OP-1:0] op_q;
  logic                  word_q;
  logic [4:0]            rd_q;
  logic                  q_neg;
  logic                  r_neg;
  logic [DW-1:0]         rem;
  logic [DW-1:0]         quo;
  logic [DW-1:0]         divisor_mag;
  logic [CW-1:0]         count;
  logic                  done_q;

  logic                  is_signed;
  logic [DW-1:0]         ext_a;
  logic [DW-1:0]         ext_b;
  logic                  neg_a;
  logic                  neg_b;
  logic [DW-1:0]         mag_a;
  logic [DW-1:0]         mag_b;
  logic [DW-1:0]         most_neg;
  logic                  b_zero;
  logic                  overflow;
  logic                  early;
  logic                  special;
  logic [DW-1:0]         special_q;
  logic [DW-1:0]         special_r;
  logic [DW-1:0]         special_res;

  logic [DW-1:0]         rem_next;
  logic [DW-1:0]         quo_next;
  logic [DW-1:0]         q_fin;
  logic [DW-1:0]         r_fin;
  logic [DW-1:0]         calc_res;

  always_comb begin
    is_signed = op_is_signed(div_op_i);
    if (word_i) begin
      ext_a    = is_signed ? {{(DW-32){dividend_i[31]}}, dividend_i[31:0]}
                           : {{(DW-32){1'b0}}, dividend_i[31:0]};
      ext_b    = is_signed ? {{(DW-32){divisor_i[31]}}, divisor_i[31:0]}
                           : {{(DW-32){1'b0}}, divisor_i[31:0]};
      most_neg = {{(DW-31){1'b1}}, 31'd0};
    end else begin
      ext_a    = dividend_i;
      ext_b    = divisor_i;
      most_neg = {1'b1, {(DW-1){1'b0}}};
    end
    neg_a    = is_signed & ext_a[DW-1];
    neg_b    = is_signed & ext_b[DW-1];
    mag_a    = neg_a ? -ext_a : ext_a;
    mag_b    = neg_b ? -ext_b : ext_b;
    b_zero   = (ext_b == '0);
    overflow = is_signed && (ext_a == most_neg) && (&ext_b);
  end

`ifdef EX_DIV_EARLY_OUT_EN
  assign early = ~b_zero & (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  assign special = b_zero | overflow | early;

  always_comb begin
    special_q = '0;
    special_r = ext_a;
    if (b_zero) begin
      special_q = '1;
      special_r = ext_a;
    end else if (overflow) begin
      special_q = ext_a;
      special_r = '0;
    end
    special_res = word_fix(op_is_rem(div_op_i) ? special_r : special_q, word_i);
  end

  ex_div_div_step #(.DW(DW)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor_mag),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_fin    = q_neg ? -quo_next : quo_next;
  assign r_fin    = r_neg ? -rem_next : rem_next;
  assign calc_res = word_fix(op_is_rem(op_q) ? r_fin : q_fin, word_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DIV_ST_IDLE;
      op_q        <= DIV_OP_DIV;
      word_q      <= 1'b0;
      rd_q        <= REG_ADDR_ZERO;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      divisor_mag <= '0;
      count       <= '0;
      done_q      <= 1'b0;
      result_o    <= DW'(ZERO_DOUBLE);
      addr_rd_o   <= REG_ADDR_ZERO;
    end else begin
      done_q <= 1'b0;
      case (state)
        DIV_ST_IDLE: begin
          if (start_i && !flush_i) begin
            op_q        <= div_op_i;
            word_q      <= word_i;
            rd_q        <= addr_rd_i;
            q_neg       <= neg_a ^ neg_b;
            r_neg       <= neg_a;
            rem         <= '0;
            // Word operands start in the upper half so 32 steps consume exactly their bits.
            quo         <= word_i ? (mag_a << 32) : mag_a;
            divisor_mag <= mag_b;
            count       <= word_i ? CW'(32) : CW'(DW);
            if (special) begin
              state     <= DIV_ST_DONE;
              done_q    <= 1'b1;
              result_o  <= special_res;
              addr_rd_o <= addr_rd_i;
            end else begin
              state <= DIV_ST_CALC;
            end
          end
        end
        DIV_ST_CALC: begin
          if (flush_i) begin
            state <= DIV_ST_IDLE;
            count <= '0;
          end else begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              state     <= DIV_ST_DONE;
              done_q    <= 1'b1;
              result_o  <= calc_res;
              addr_rd_o <= rd_q;
            end
          end
        end
        DIV_ST_DONE: state <= DIV_ST_IDLE;
        default:     state <= DIV_ST_IDLE;
      endcase
    end
  end

  assign hold_req_o  = ~rst & (((state == DIV_ST_IDLE) & start_i & ~flush_i) | (state == DIV_ST_CALC));
  assign done_o      = done_q & ~flush_i;
  assign reg_wr_en_o = done_o;

endmodule

`default_nettype wire

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div (latency, results, flush and reset behaviour).
`default_nettype none

module tb_ex_div;
  import ex_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  div_op_i;
  logic        word_i;
  logic [63:0] dividend_i;
  logic [63:0] divisor_i;
  logic [4:0]  addr_rd_i;
  logic        flush_i;
  logic        hold_req_o;
  logic        done_o;
  logic [63:0] result_o;
  logic [4:0]  addr_rd_o;
  logic        reg_wr_en_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_div #(.DW(64), .CW(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .div_op_i    (div_op_i),
    .word_i      (word_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .addr_rd_i   (addr_rd_i),
    .flush_i     (flush_i),
    .hold_req_o  (hold_req_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .addr_rd_o   (addr_rd_o),
    .reg_wr_en_o (reg_wr_en_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] exp_res, input int exp_hold);
    int holds;
    holds = 0;
    @(negedge clk);
    div_op_i = op; word_i = w; dividend_i = a; divisor_i = b; addr_rd_i = rd; start_i = 1'b1;
    #1;
    while (hold_req_o === 1'b1 && holds < 200) begin
      holds++;
      @(negedge clk);
      start_i = 1'b0;
      #1;
    end
    start_i = 1'b0;
    check({tag, " hold"}, 64'(holds), 64'(exp_hold));
    check({tag, " done"}, 64'(done_o), 64'd1);
    check({tag, " wr_en"}, 64'(reg_wr_en_o), 64'd1);
    check({tag, " result"}, result_o, exp_res);
    check({tag, " rd"}, 64'(addr_rd_o), 64'(rd));
    @(negedge clk);
    #1;
    check({tag, " done_clr"}, 64'(done_o), 64'd0);
    check({tag, " result_held"}, result_o, exp_res);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start_i = 1'b1; div_op_i = DIV_OP_DIV; word_i = 1'b0;
    dividend_i = 64'd100; divisor_i = 64'd7; addr_rd_i = 5'd3; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst hold", 64'(hold_req_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("rst wr_en", 64'(reg_wr_en_o), 64'd0);
    check("rst result", result_o, 64'd0);
    check("rst rd", 64'(addr_rd_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_div("div_100_7",   DIV_OP_DIV,  1'b0, 64'd100, 64'd7, 5'd5, 64'd14, 65);
    run_div("rem_m100_7",  DIV_OP_REM,  1'b0, -64'sd100, 64'd7, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_div("div_m100_7",  DIV_OP_DIV,  1'b0, -64'sd100, 64'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_div("divu_by0",    DIV_OP_DIVU, 1'b0, 64'h1234, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_div("remu_by0",    DIV_OP_REMU, 1'b0, 64'h1234, 64'd0, 5'd9, 64'h1234, 1);
    run_div("div_ovf",     DIV_OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10,
            64'h8000_0000_0000_0000, 1);
    run_div("rem_ovf",     DIV_OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
            64'd0, 1);
    run_div("divuw_ff_1",  DIV_OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd12,
            64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_div("divw_m7_2",   DIV_OP_DIV,  1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2, 5'd13,
            64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_div("divw_ovf",    DIV_OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd14,
            64'hFFFF_FFFF_8000_0000, 1);
    run_div("remu_big",    DIV_OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 5'd15,
            64'h7FFF_FFFF_FFFF_FFFE, 65);
`ifdef EX_DIV_EARLY_OUT_EN
    run_div("div_3_7",     DIV_OP_DIV,  1'b0, 64'd3, 64'd7, 5'd16, 64'd0, 1);
`else
    run_div("div_3_7",     DIV_OP_DIV,  1'b0, 64'd3, 64'd7, 5'd16, 64'd0, 65);
`endif

    // Flush at the tenth CALC cycle must abort with no writeback.
    @(negedge clk);
    div_op_i = DIV_OP_DIV; word_i = 1'b0; dividend_i = 64'd100; divisor_i = 64'd7;
    addr_rd_i = 5'd20; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush hold", 64'(hold_req_o), 64'd0);
    check("flush done", 64'(done_o), 64'd0);
    dones = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      #1;
      if (done_o === 1'b1 || hold_req_o === 1'b1) dones++;
    end
    check("flush quiet", 64'(dones), 64'd0);

    // A start presented together with flush in IDLE is dropped.
    @(negedge clk);
    div_op_i = DIV_OP_DIVU; dividend_i = 64'h55; divisor_i = 64'd0; start_i = 1'b1; flush_i = 1'b1;
    #1;
    check("idle_flush hold", 64'(hold_req_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (done_o === 1'b1) dones++;
    end
    check("idle_flush no_done", 64'(dones), 64'd0);

    // Reset mid-CALC returns every output to its reset value.
    @(negedge clk);
    div_op_i = DIV_OP_DIV; word_i = 1'b0; dividend_i = 64'd1000; divisor_i = 64'd3;
    addr_rd_i = 5'd21; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst hold", 64'(hold_req_o), 64'd0);
    check("midrst done", 64'(done_o), 64'd0);
    check("midrst wr_en", 64'(reg_wr_en_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    check("midrst rd", 64'(addr_rd_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("after_rst",   DIV_OP_DIVU, 1'b0, 64'd1000, 64'd3, 5'd22, 64'd333, 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
